// File: rtl/clk_fail_monitor.sv
// Reference-domain health monitor and failover selector for CLK_NUM candidate clocks.
// Define CLK_FAIL_MON_IRQ_EN to add a sticky clock-failure interrupt (irq, irq_clr).
module clk_fail_monitor #(
  parameter int CLK_NUM     = 4,
  parameter int WIN_CYC     = 64,
  parameter int CNT_MIN     = 12,
  parameter int CNT_MAX     = 20,
  parameter int FAIL_WIN    = 2,
  parameter int RECOVER_WIN = 4,
  parameter int SETTLE_CYC  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CLK_NUM-1:0]         mon_tgl,
  input  logic [$clog2(CLK_NUM)-1:0] sel_req,
`ifdef CLK_FAIL_MON_IRQ_EN
  input  logic [CLK_NUM-1:0]         irq_clr,
  output logic                       irq,
`endif
  output logic [CLK_NUM-1:0]         clk_fail,
  output logic [$clog2(CLK_NUM)-1:0] sel,
  output logic                       all_fail,
  output logic                       sel_busy
);

  localparam int SW  = $clog2(CLK_NUM);
  localparam int WW  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int CW  = $clog2(CNT_MAX + 2);
  localparam int STM = (FAIL_WIN > RECOVER_WIN) ? FAIL_WIN : RECOVER_WIN;
  localparam int STW = $clog2(STM + 1);
  localparam int HW  = $clog2(SETTLE_CYC + 1);

  localparam logic [WW-1:0]  WIN_LAST  = WW'(WIN_CYC - 1);
  localparam logic [CW-1:0]  CNT_SAT   = CW'(CNT_MAX + 1);
  localparam logic [CW-1:0]  CNT_LO    = CW'(CNT_MIN);
  localparam logic [CW-1:0]  CNT_HI    = CW'(CNT_MAX);
  localparam logic [STW-1:0] FAIL_LIM  = STW'(FAIL_WIN);
  localparam logic [STW-1:0] RECOV_LIM = STW'(RECOVER_WIN);
  localparam logic [HW-1:0]  SETTLE_LD = HW'(SETTLE_CYC - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

  logic [CLK_NUM-1:0] sync1_r, sync2_r, edge_r, pulse_s;
  logic [WW-1:0]      win_cnt_r;
  logic               win_end_s;
  logic [CW-1:0]      edge_cnt_r [CLK_NUM];
  logic [CW-1:0]      edge_sum_s [CLK_NUM];
  logic [STW-1:0]     bad_streak_r [CLK_NUM];
  logic [STW-1:0]     good_streak_r [CLK_NUM];
  logic [STW-1:0]     bad_next_s [CLK_NUM];
  logic [STW-1:0]     good_next_s [CLK_NUM];
  logic [CLK_NUM-1:0] win_good_s, fail_next_s, clk_fail_r;
  logic               all_fail_r;
  state_t             state_r;
  logic [SW-1:0]      sel_r, target_s, low_idx_s;
  logic [HW-1:0]      settle_r;
  logic               sel_busy_r, req_ok_s, any_ok_s;

  assign pulse_s   = sync2_r ^ edge_r;
  assign win_end_s = (win_cnt_r == WIN_LAST);

  // Per-channel window count, window verdict, streak and fail-flag next state
  always_comb begin
    for (int n = 0; n < CLK_NUM; n++) begin
      if (pulse_s[n] && (edge_cnt_r[n] != CNT_SAT)) begin
        edge_sum_s[n] = edge_cnt_r[n] + CW'(1);
      end else begin
        edge_sum_s[n] = edge_cnt_r[n];
      end
      win_good_s[n] = (edge_sum_s[n] >= CNT_LO) && (edge_sum_s[n] <= CNT_HI);
      if (!win_end_s) begin
        bad_next_s[n]  = bad_streak_r[n];
        good_next_s[n] = good_streak_r[n];
      end else if (win_good_s[n]) begin
        bad_next_s[n]  = '0;
        good_next_s[n] = (good_streak_r[n] == RECOV_LIM) ? good_streak_r[n]
                                                         : good_streak_r[n] + STW'(1);
      end else begin
        good_next_s[n] = '0;
        bad_next_s[n]  = (bad_streak_r[n] == FAIL_LIM) ? bad_streak_r[n]
                                                       : bad_streak_r[n] + STW'(1);
      end
      if (win_end_s && (bad_next_s[n] == FAIL_LIM)) begin
        fail_next_s[n] = 1'b1;
      end else if (win_end_s && (good_next_s[n] == RECOV_LIM)) begin
        fail_next_s[n] = 1'b0;
      end else begin
        fail_next_s[n] = clk_fail_r[n];
      end
    end
  end

  // Failover target: healthy request, else lowest healthy clock, else keep current
  always_comb begin
    req_ok_s  = 1'b0;
    any_ok_s  = 1'b0;
    low_idx_s = '0;
    for (int n = CLK_NUM - 1; n >= 0; n--) begin
      any_ok_s  = any_ok_s | ~clk_fail_r[n];
      low_idx_s = clk_fail_r[n] ? low_idx_s : SW'(n);
      req_ok_s  = req_ok_s | ((SW'(n) == sel_req) & ~clk_fail_r[n]);
    end
    if (req_ok_s) begin
      target_s = sel_req;
    end else if (any_ok_s) begin
      target_s = low_idx_s;
    end else begin
      target_s = sel_r;
    end
  end

  // Input capture, window timing and per-channel statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r    <= '0;
      sync2_r    <= '0;
      edge_r     <= '0;
      win_cnt_r  <= '0;
      clk_fail_r <= '0;
      all_fail_r <= 1'b0;
      for (int n = 0; n < CLK_NUM; n++) begin
        edge_cnt_r[n]    <= '0;
        bad_streak_r[n]  <= '0;
        good_streak_r[n] <= '0;
      end
    end else begin
      sync1_r    <= mon_tgl;
      sync2_r    <= sync1_r;
      edge_r     <= sync2_r;
      win_cnt_r  <= win_end_s ? '0 : win_cnt_r + WW'(1);
      clk_fail_r <= fail_next_s;
      all_fail_r <= &fail_next_s;
      for (int n = 0; n < CLK_NUM; n++) begin
        edge_cnt_r[n]    <= win_end_s ? '0 : edge_sum_s[n];
        bad_streak_r[n]  <= bad_next_s[n];
        good_streak_r[n] <= good_next_s[n];
      end
    end
  end

  // Selection FSM; expiry of HOLD re-evaluates the target in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RUN;
      sel_r      <= '0;
      settle_r   <= '0;
      sel_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (target_s != sel_r) begin
            sel_r      <= target_s;
            settle_r   <= SETTLE_LD;
            sel_busy_r <= 1'b1;
            state_r    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (settle_r != '0) begin
            settle_r <= settle_r - HW'(1);
          end else if (target_s != sel_r) begin
            sel_r    <= target_s;
            settle_r <= SETTLE_LD;
          end else begin
            sel_busy_r <= 1'b0;
            state_r    <= ST_RUN;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          sel_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign clk_fail = clk_fail_r;
  assign sel      = sel_r;
  assign all_fail = all_fail_r;
  assign sel_busy = sel_busy_r;

`ifdef CLK_FAIL_MON_IRQ_EN
  logic [CLK_NUM-1:0] irq_stat_r, irq_stat_next_s;
  logic               irq_r;

  // A new failure edge wins over a simultaneous clear of the same bit
  assign irq_stat_next_s = (irq_stat_r & ~irq_clr) | (fail_next_s & ~clk_fail_r);

  // Sticky failure status and interrupt output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_stat_r <= '0;
      irq_r      <= 1'b0;
    end else begin
      irq_stat_r <= irq_stat_next_s;
      irq_r      <= |irq_stat_next_s;
    end
  end

  assign irq = irq_r;
`endif

endmodule

// File: tb/tb_clk_fail_monitor.sv
// Scoreboard bench for clk_fail_monitor: window-level reference model feeds an expected-output
// queue each clock; a negedge monitor pops and compares.
module tb_clk_fail_monitor;
  localparam int N   = 4;
  localparam int WIN = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   mon_tgl;
  logic [1:0]     sel_req;
  logic [N-1:0]   irq_clr;
  logic [N-1:0]   clk_fail;
  logic [1:0]     sel;
  logic           all_fail, sel_busy;
`ifdef CLK_FAIL_MON_IRQ_EN
  logic           irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_fail_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .mon_tgl  (mon_tgl),
    .sel_req  (sel_req),
`ifdef CLK_FAIL_MON_IRQ_EN
    .irq_clr  (irq_clr),
    .irq      (irq),
`endif
    .clk_fail (clk_fail),
    .sel      (sel),
    .all_fail (all_fail),
    .sel_busy (sel_busy)
  );

  typedef struct packed {
    logic [N-1:0] fail;
    logic [1:0]   sel;
    logic         af;
    logic         busy;
    logic         irq;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int           m_cnt[N], m_bad[N], m_good[N];
  logic [N-1:0] m_fail, m_stat, h1, h2, h3;
  int           m_sel, m_left, m_k;

  function automatic int pick_target(input logic [N-1:0] f, input int req, input int cur);
    if (req < N && !f[req]) return req;
    for (int n = 0; n < N; n++) if (!f[n]) return n;
    return cur;
  endfunction

  // Reference model: transitions counted 3 cycles late, judged per window of WIN cycles
  always @(posedge clk) begin : ref_model
    logic [N-1:0] pulse, nf;
    int t;
    exp_t e;
    if (rst) begin
      for (int n = 0; n < N; n++) begin m_cnt[n] = 0; m_bad[n] = 0; m_good[n] = 0; end
      m_fail = '0; m_stat = '0; h1 = '0; h2 = '0; h3 = '0;
      m_sel = 0; m_left = 0; m_k = 0;
    end else begin
      pulse = h2 ^ h3;
      h3 = h2; h2 = h1; h1 = mon_tgl;
      for (int n = 0; n < N; n++) if (pulse[n] && m_cnt[n] < 21) m_cnt[n]++;
      t = pick_target(m_fail, int'(sel_req), m_sel);
      if (m_left > 0) m_left--;
      if (m_left == 0 && t != m_sel) begin m_sel = t; m_left = 16; end
      nf = m_fail;
      if (m_k % WIN == WIN - 1) begin
        for (int n = 0; n < N; n++) begin
          if (m_cnt[n] >= 12 && m_cnt[n] <= 20) begin m_good[n]++; m_bad[n] = 0; end
          else begin m_bad[n]++; m_good[n] = 0; end
          if (m_bad[n] >= 2) nf[n] = 1'b1;
          else if (m_good[n] >= 4) nf[n] = 1'b0;
          m_cnt[n] = 0;
        end
      end
      m_stat = (m_stat & ~irq_clr) | (nf & ~m_fail);
      m_fail = nf;
      m_k++;
    end
    e.fail = m_fail; e.sel = 2'(m_sel); e.af = &m_fail; e.busy = (m_left > 0); e.irq = |m_stat;
    exp_q.push_back(e);
  end

  // Monitor: compare DUT outputs against the queued expectation on the falling edge
  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.fail = clk_fail; a.sel = sel; a.af = all_fail; a.busy = sel_busy;
`ifdef CLK_FAIL_MON_IRQ_EN
      a.irq = irq;
`else
      a.irq = e.irq;
`endif
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got fail=%b sel=%0d all=%b busy=%b irq=%b, want fail=%b sel=%0d all=%b busy=%b irq=%b",
                 $time, a.fail, a.sel, a.af, a.busy, a.irq, e.fail, e.sel, e.af, e.busy, e.irq);
      end
    end
  end

  // Stimulus driver: each toggle flips every gap[n] cycles (0 = stopped)
  int gap[N], ph[N];
  always @(posedge clk) begin : driver
    #1;
    for (int n = 0; n < N; n++) begin
      if (gap[n] != 0) begin
        ph[n]++;
        if (ph[n] >= gap[n]) begin mon_tgl[n] = ~mon_tgl[n]; ph[n] = 0; end
      end
    end
    irq_clr = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_all(input int g);
    for (int n = 0; n < N; n++) gap[n] = g;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int b = 0;
    while ((m_k % WIN) != p && b < 4 * WIN) begin cyc(1); b++; end
    chk("phase_wait", int'((m_k % WIN) == p), 1);
  endtask

  int gap_tbl[7] = '{0, 2, 3, 4, 4, 5, 6};

  initial begin
    int k1;
    rst = 1'b1; mon_tgl = '0; sel_req = 2'd0; irq_clr = '0;
    for (int n = 0; n < N; n++) begin gap[n] = 4; ph[n] = $urandom_range(3); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    // healthy clocks, sel follows request
    cyc(3 * WIN); sel_req = 2'd2; cyc(2 * WIN);
    // requested clock stops -> fallback to lowest healthy
    sel_req = 2'd1; gap[1] = 0; cyc(4 * WIN);
    // overspeed clock 3 fails, then recovers after 4 good windows
    gap[1] = 4; gap[3] = 2; cyc(3 * WIN); gap[3] = 4; cyc(6 * WIN);
    // every clock stops, then clock 2 recovers
    set_all(0); cyc(3 * WIN); gap[2] = 4; cyc(6 * WIN);
    // changes during HOLD, with a fail flag landing inside the hold window
    set_all(4); sel_req = 2'd0; cyc(6 * WIN);
    wait_phase(0); gap[3] = 0; cyc(WIN);
    wait_phase(56); sel_req = 2'd3; cyc(4); sel_req = 2'd1; cyc(3 * WIN);
    // randomized operation
    for (int w = 0; w < 30; w++) begin
      for (int n = 0; n < N; n++) if ($urandom_range(1) == 1) gap[n] = gap_tbl[$urandom_range(6)];
      sel_req = 2'($urandom);
      k1 = $urandom_range(62) + 1;
      cyc(k1); sel_req = 2'($urandom); cyc(WIN - k1);
    end
    // reset in the middle of a window
    set_all(4); gap[1] = 0; sel_req = 2'd3; cyc(8 * WIN + 20);
    @(negedge clk); #2;
    chk("pre_rst_fail", int'(clk_fail), 2);
    chk("pre_rst_sel", int'(sel), 3);
    rst = 1'b1; #1;
    chk("rst_fail", int'(clk_fail), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_all_fail", int'(all_fail), 0);
    chk("rst_busy", int'(sel_busy), 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    cyc(3 * WIN);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
